// File: rtl/plot_pkg.sv
// Shared types and geometry constants for the pixel-plot scheduler.
package plot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BOX   = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } plot_state_t;

    localparam int X_SCREEN_PIXELS_DEF = 160;
    localparam int Y_SCREEN_PIXELS_DEF = 120;

    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int COL_W = 3;

endpackage

// File: rtl/raster_walker.sv
// Row-major 2-D counter with runtime extents; exposes both the registered
// position and the position it will take on the next edge.
module raster_walker
    import plot_pkg::*;
(
    input  logic           iClock,
    input  logic           iResetn,
    input  logic           start,
    input  logic           advance,
    input  logic [X_W-1:0] width,
    input  logic [Y_W-1:0] height,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [X_W-1:0] x_nxt,
    output logic [Y_W-1:0] y_nxt,
    output logic           last
);

    logic x_end, y_end;

    assign x_end = (x == width - X_W'(1));
    assign y_end = (y == height - Y_W'(1));
    assign last  = x_end && y_end;

    always_comb begin
        x_nxt = x;
        y_nxt = y;
        if (start) begin
            x_nxt = '0;
            y_nxt = '0;
        end else if (advance) begin
            if (x_end) begin
                x_nxt = '0;
                y_nxt = y_end ? '0 : y + Y_W'(1);
            end else begin
                x_nxt = x + X_W'(1);
            end
        end
    end

    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            x <= '0;
            y <= '0;
        end else begin
            x <= x_nxt;
            y <= y_nxt;
        end
    end

endmodule

// File: rtl/plot_scheduler.sv
// Shares the single VGA pixel-write port between box and clear requesters,
// one pixel per clock, clear having priority.
module plot_scheduler
    import plot_pkg::*;
#(
    parameter int X_SCREEN_PIXELS = X_SCREEN_PIXELS_DEF,
    parameter int Y_SCREEN_PIXELS = Y_SCREEN_PIXELS_DEF,
    parameter int BOX_DIM         = 4
) (
    input  logic             iClock,
    input  logic             iResetn,
    input  logic             iBoxReq,
    input  logic [X_W-1:0]   iBoxX,
    input  logic [Y_W-1:0]   iBoxY,
    input  logic [COL_W-1:0] iBoxColour,
    input  logic             iClearReq,
    input  logic [COL_W-1:0] iClearColour,
    output logic             oBoxAck,
    output logic             oClearAck,
    output logic [X_W-1:0]   oX,
    output logic [Y_W-1:0]   oY,
    output logic [COL_W-1:0] oColour,
    output logic             oPlot,
    output logic             oBusy,
    output logic             oDone
);

    plot_state_t state, state_n;

    logic [X_W-1:0]   box_x, box_x_n;
    logic [Y_W-1:0]   box_y, box_y_n;
    logic [COL_W-1:0] box_col, box_col_n, clr_col, clr_col_n;

    logic             start, adv, pix_box, pix_clr;
    logic             box_ack_n, clr_ack_n;
    logic [X_W-1:0]   wx, wx_nxt, x_n;
    logic [Y_W-1:0]   wy, wy_nxt, y_n;
    logic [COL_W-1:0] col_n;
    logic             w_last, plot_n;
    logic [X_W:0]     sum_x;
    logic [Y_W:0]     sum_y;
    logic [X_W-1:0]   ext_w;
    logic [Y_W-1:0]   ext_h;

    // Extents only matter while advancing; start always loads (0,0).
    assign ext_w = (state == CLEAR) ? X_W'(X_SCREEN_PIXELS) : X_W'(BOX_DIM);
    assign ext_h = (state == CLEAR) ? Y_W'(Y_SCREEN_PIXELS) : Y_W'(BOX_DIM);

    raster_walker u_walker (
        .iClock  (iClock),
        .iResetn (iResetn),
        .start   (start),
        .advance (adv),
        .width   (ext_w),
        .height  (ext_h),
        .x       (wx),
        .y       (wy),
        .x_nxt   (wx_nxt),
        .y_nxt   (wy_nxt),
        .last    (w_last)
    );

    // Wide sums so an origin near the edge cannot wrap back on screen.
    assign sum_x = {1'b0, box_x_n} + {1'b0, wx_nxt};
    assign sum_y = {1'b0, box_y_n} + {1'b0, wy_nxt};

    always_comb begin
        state_n   = state;
        start     = 1'b0;
        adv       = 1'b0;
        pix_box   = 1'b0;
        pix_clr   = 1'b0;
        box_ack_n = 1'b0;
        clr_ack_n = 1'b0;
        box_x_n   = box_x;
        box_y_n   = box_y;
        box_col_n = box_col;
        clr_col_n = clr_col;
        unique case (state)
            IDLE: begin
                if (iClearReq) begin
                    state_n   = CLEAR;
                    start     = 1'b1;
                    pix_clr   = 1'b1;
                    clr_ack_n = 1'b1;
                    clr_col_n = iClearColour;
                end else if (iBoxReq) begin
                    state_n   = BOX;
                    start     = 1'b1;
                    pix_box   = 1'b1;
                    box_ack_n = 1'b1;
                    box_x_n   = iBoxX;
                    box_y_n   = iBoxY;
                    box_col_n = iBoxColour;
                end
            end
            BOX: begin
                if (w_last) state_n = DONE;
                else begin
                    adv     = 1'b1;
                    pix_box = 1'b1;
                end
            end
            CLEAR: begin
                if (w_last) state_n = DONE;
                else begin
                    adv     = 1'b1;
                    pix_clr = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The output registers are loaded with the pixel the walker moves to.
    always_comb begin
        x_n    = oX;
        y_n    = oY;
        col_n  = oColour;
        plot_n = 1'b0;
        if (pix_box) begin
            x_n    = sum_x[X_W-1:0];
            y_n    = sum_y[Y_W-1:0];
            col_n  = box_col_n;
            plot_n = (sum_x < (X_W+1)'(X_SCREEN_PIXELS)) &&
                     (sum_y < (Y_W+1)'(Y_SCREEN_PIXELS));
        end else if (pix_clr) begin
            x_n    = wx_nxt;
            y_n    = wy_nxt;
            col_n  = clr_col_n;
            plot_n = 1'b1;
        end
    end

    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            state     <= IDLE;
            box_x     <= '0;
            box_y     <= '0;
            box_col   <= '0;
            clr_col   <= '0;
            oBoxAck   <= 1'b0;
            oClearAck <= 1'b0;
            oX        <= '0;
            oY        <= '0;
            oColour   <= '0;
            oPlot     <= 1'b0;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
        end else begin
            state     <= state_n;
            box_x     <= box_x_n;
            box_y     <= box_y_n;
            box_col   <= box_col_n;
            clr_col   <= clr_col_n;
            oBoxAck   <= box_ack_n;
            oClearAck <= clr_ack_n;
            oX        <= x_n;
            oY        <= y_n;
            oColour   <= col_n;
            oPlot     <= plot_n;
            oBusy     <= (state_n == BOX) || (state_n == CLEAR);
            oDone     <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_plot_scheduler.sv
// Directed scoreboard bench for plot_scheduler: expected pixel stream is
// queued when a request is issued and compared cycle by cycle.
module tb_plot_scheduler;

    logic       iClock = 1'b0;
    logic       iResetn, iBoxReq, iClearReq;
    logic [7:0] iBoxX;
    logic [6:0] iBoxY;
    logic [2:0] iBoxColour, iClearColour;
    logic       oBoxAck, oClearAck, oPlot, oBusy, oDone;
    logic [7:0] oX;
    logic [6:0] oY;
    logic [2:0] oColour;

    typedef struct packed {
        logic       back;
        logic       cack;
        logic       busy;
        logic       done;
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } obs_t;

    obs_t obs, exp_e, last_e;
    obs_t sb[$];
    int   checks = 0;
    int   errors = 0;

    assign obs = {oBoxAck, oClearAck, oBusy, oDone, oPlot, oX, oY, oColour};

    plot_scheduler dut (
        .iClock(iClock), .iResetn(iResetn),
        .iBoxReq(iBoxReq), .iBoxX(iBoxX), .iBoxY(iBoxY), .iBoxColour(iBoxColour),
        .iClearReq(iClearReq), .iClearColour(iClearColour),
        .oBoxAck(oBoxAck), .oClearAck(oClearAck),
        .oX(oX), .oY(oY), .oColour(oColour),
        .oPlot(oPlot), .oBusy(oBusy), .oDone(oDone)
    );

    always #5 iClock = ~iClock;

    task automatic chk(input string tag, input obs_t o, input obs_t e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic push_box(input int bx, input int by, input logic [2:0] c);
        obs_t e;
        for (int k = 0; k < 16; k++) begin
            int sx = bx + k % 4;
            int sy = by + k / 4;
            e      = '0;
            e.back = (k == 0);
            e.busy = 1'b1;
            e.plot = (sx < 160) && (sy < 120);
            e.x    = 8'(sx);
            e.y    = 7'(sy);
            e.c    = c;
            sb.push_back(e);
        end
    endtask

    task automatic push_clear(input logic [2:0] c, input int n);
        obs_t e;
        for (int k = 0; k < n; k++) begin
            e      = '0;
            e.cack = (k == 0);
            e.busy = 1'b1;
            e.plot = 1'b1;
            e.x    = 8'(k % 160);
            e.y    = 7'(k / 160);
            e.c    = c;
            sb.push_back(e);
        end
    endtask

    // Called at the negedge of the first pixel cycle; leaves at the
    // negedge after the last compared pixel.
    task automatic drain(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            exp_e = sb.pop_front();
            chk(tag, obs, exp_e);
            last_e = exp_e;
            @(negedge iClock);
        end
    endtask

    task automatic check_done(input string tag);
        exp_e      = '0;
        exp_e.done = 1'b1;
        exp_e.x    = last_e.x;
        exp_e.y    = last_e.y;
        chk(tag, obs & ~obs_t'(3'h7), exp_e);
        @(negedge iClock);
    endtask

    initial begin
        iResetn = 1'b0; iBoxReq = 1'b0; iClearReq = 1'b0;
        iBoxX = '0; iBoxY = '0; iBoxColour = '0; iClearColour = '0;
        repeat (3) @(negedge iClock);
        chk("reset_outputs", obs, '0);
        iResetn = 1'b1;
        @(negedge iClock);
        chk("idle_after_reset", obs, '0);

        // Basic box.
        iBoxReq = 1'b1; iBoxX = 8'd10; iBoxY = 7'd20; iBoxColour = 3'b100;
        @(negedge iClock);
        iBoxReq = 1'b0;
        push_box(10, 20, 3'b100);
        drain("box_basic", 16);
        check_done("box_basic_done");
        exp_e = '0; exp_e.x = last_e.x; exp_e.y = last_e.y; exp_e.c = last_e.c;
        chk("box_idle_hold", obs, exp_e);

        // Exhaustive clear.
        iClearReq = 1'b1; iClearColour = 3'd0;
        @(negedge iClock);
        iClearReq = 1'b0;
        push_clear(3'd0, 19200);
        drain("clear_full", 19200);
        check_done("clear_full_done");

        // Simultaneous: clear wins, held box starts one cycle after DONE.
        iClearReq = 1'b1; iClearColour = 3'd2;
        iBoxReq = 1'b1; iBoxX = 8'd50; iBoxY = 7'd60; iBoxColour = 3'd6;
        @(negedge iClock);
        iClearReq = 1'b0;
        push_clear(3'd2, 19200);
        drain("simul_clear", 19200);
        check_done("simul_clear_done");
        exp_e = '0; exp_e.x = last_e.x; exp_e.y = last_e.y; exp_e.c = 3'd2;
        chk("simul_idle_gap", obs, exp_e);
        @(negedge iClock);
        iBoxReq = 1'b0;
        push_box(50, 60, 3'd6);
        drain("simul_box", 16);
        check_done("simul_box_done");

        // Clipped box at the bottom-right corner.
        iBoxReq = 1'b1; iBoxX = 8'd158; iBoxY = 7'd118; iBoxColour = 3'd1;
        @(negedge iClock);
        iBoxReq = 1'b0;
        push_box(158, 118, 3'd1);
        drain("box_clip", 16);
        check_done("box_clip_done");

        // Reset in the middle of a clear.
        iClearReq = 1'b1; iClearColour = 3'd5;
        @(negedge iClock);
        iClearReq = 1'b0;
        push_clear(3'd5, 500);
        drain("clear_pre_reset", 500);
        iResetn = 1'b0;
        @(negedge iClock);
        chk("reset_abort", obs, '0);
        iResetn = 1'b1;
        @(negedge iClock);
        chk("reset_no_done", obs, '0);

        // Box after reset, operands changed mid-operation.
        iBoxReq = 1'b1; iBoxX = 8'd30; iBoxY = 7'd40; iBoxColour = 3'd5;
        @(negedge iClock);
        iBoxReq = 1'b0; iBoxX = 8'd0; iBoxY = 7'd0; iBoxColour = 3'd7;
        push_box(30, 40, 3'd5);
        drain("box_stable", 16);
        check_done("box_stable_done");

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
